// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: paced FIFO read-side PRBS checker; define FIFO_CHK_ERR_CAPTURE_EN to capture the first mismatch
module fifo_rd_checker #(
  parameter int FIFO_WIDTH = 8,
  parameter int CNT_W = 16,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] PACE_SEED = 16'h1D0F
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_W-1:0]      num_words_i,
  input  logic [1:0]            mode_i,
  input  logic                  empty_i,
  output logic                  rd_en_o,
  input  logic [FIFO_WIDTH-1:0] rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CNT_W-1:0]      word_cnt_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [FIFO_WIDTH-1:0] err_exp_o,
  output logic [FIFO_WIDTH-1:0] err_act_o,
  output logic [CNT_W-1:0]      err_idx_o
);
  localparam logic [15:0] D_SEED = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [15:0] P_SEED = (PACE_SEED == 16'h0) ? 16'h1D0F : PACE_SEED;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [15:0] data_lfsr, pace_lfsr;
  logic [CNT_W-1:0] target, issued;
  logic rd_vld_q, pace_ok, mis, go;
  function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  // pacing decision from the mode selected this cycle
  always_comb pace_ok = (mode_i == 2'd0) ? 1'b0 : (mode_i == 2'd1) ? 1'b1 :
                        (mode_i == 2'd2) ? pace_lfsr[0] : (pace_lfsr[2:0] == 3'b001);
  assign rd_en_o = (state == RUN) & pace_ok & ~empty_i & (issued < target) & ~abort_i;
  assign mis = rd_data_i != data_lfsr[FIFO_WIDTH-1:0];
  assign go = start_i & ((state == IDLE) | (state == DONE));
  assign busy_o = (state == RUN) | (state == DRAIN);
  assign done_o = state == DONE;
  assign pass_o = done_o & (err_cnt_o == '0);
  // run control, pop issue tracking and the one-cycle-delayed compare
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      data_lfsr <= D_SEED;
      pace_lfsr <= P_SEED;
      target <= '0;
      issued <= '0;
      rd_vld_q <= 1'b0;
      word_cnt_o <= '0;
      err_cnt_o <= '0;
    end else if (abort_i) begin
      state <= IDLE;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en_o;
      if (rd_vld_q) begin
        word_cnt_o <= word_cnt_o + CNT_W'(1);
        data_lfsr <= lfsr_nx(data_lfsr);
        if (mis && ~&err_cnt_o) err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
      if (state == RUN) pace_lfsr <= lfsr_nx(pace_lfsr);
      if (rd_en_o) issued <= issued + CNT_W'(1);
      if (go) begin
        state <= RUN;
        target <= num_words_i;
        issued <= '0;
        word_cnt_o <= '0;
        err_cnt_o <= '0;
        data_lfsr <= D_SEED;
      end else if (state == RUN && issued == target) state <= DRAIN;
      else if (state == DRAIN && !rd_vld_q) state <= DONE;
    end
  end
`ifdef FIFO_CHK_ERR_CAPTURE_EN
  // latch expected/actual/index of the first mismatch of each run
  always_ff @(posedge clk_i) begin
    if (rst_i || (!abort_i && go)) begin
      err_exp_o <= '0;
      err_act_o <= '0;
      err_idx_o <= '0;
    end else if (!abort_i && rd_vld_q && mis && err_cnt_o == '0) begin
      err_exp_o <= data_lfsr[FIFO_WIDTH-1:0];
      err_act_o <= rd_data_i;
      err_idx_o <= word_cnt_o;
    end
  end
`else
  assign err_exp_o = '0;
  assign err_act_o = '0;
  assign err_idx_o = '0;
`endif
endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb_fifo_rd_checker: scoreboard bench for fifo_rd_checker with a behavioural FIFO and pacing model
module tb_fifo_rd_checker;
  logic clk = 1'b0;
  logic rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, empty_i, rd_en_o;
  logic [15:0] num_words_i = '0;
  logic [1:0] mode_i = 2'd1;
  logic [7:0] rd_data_i = '0;
  logic busy_o, done_o, pass_o;
  logic [15:0] word_cnt_o, err_cnt_o, err_idx_o;
  logic [7:0] err_exp_o, err_act_o;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0;
  logic force_empty = 1'b0, popped = 1'b0;
  logic [1:0] m_st = 2'd0;
  logic [15:0] m_pace = 16'h1D0F;
  int m_iss = 0, m_tgt = 0;
  logic m_vld = 1'b0;
  int last_ncyc = 0;
  typedef struct {
    int words;
    int errs;
    logic pass;
    int idx;
    logic [7:0] ex;
    logic [7:0] ac;
  } exp_t;
  exp_t sb[$];

  assign empty_i = force_empty || (rd_ptr >= wr_ptr);

  always #5 clk = ~clk;

  fifo_rd_checker dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .num_words_i(num_words_i), .mode_i(mode_i), .empty_i(empty_i),
    .rd_en_o(rd_en_o), .rd_data_i(rd_data_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .word_cnt_o(word_cnt_o), .err_cnt_o(err_cnt_o),
    .err_exp_o(err_exp_o), .err_act_o(err_act_o), .err_idx_o(err_idx_o)
  );

  function automatic logic [15:0] prbs_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    logic en, pk;
    #1;
    pk = (mode_i == 2'd0) ? 1'b0 : (mode_i == 2'd1) ? 1'b1 :
         (mode_i == 2'd2) ? m_pace[0] : (m_pace[2:0] == 3'b001);
    en = (m_st == 2'd1) && pk && !empty_i && (m_iss < m_tgt) && !abort_i;
    if (!rst_i) check("rd_en", rd_en_o, en);
    popped = !rst_i && rd_en_o;
    @(posedge clk);
    #1;
    if (popped && rd_ptr < wr_ptr) begin
      rd_data_i = mem[rd_ptr];
      rd_ptr++;
    end
    if (rst_i) begin
      m_st = 2'd0; m_pace = 16'h1D0F; m_iss = 0; m_tgt = 0; m_vld = 1'b0;
    end else if (abort_i) begin
      m_st = 2'd0; m_vld = 1'b0;
    end else begin
      if ((m_st == 2'd0 || m_st == 2'd3) && start_i) begin
        m_st = 2'd1; m_tgt = int'(num_words_i); m_iss = 0;
      end else if (m_st == 2'd1) begin
        m_pace = prbs_step(m_pace);
        if (m_iss == m_tgt) m_st = 2'd2;
        else if (en) m_iss++;
      end else if (m_st == 2'd2 && !m_vld) m_st = 2'd3;
      m_vld = en;
    end
  endtask

  task automatic run(input string tag, input int num, input logic [1:0] md,
                     input int bad_idx, input logic [7:0] bad_val, input int emp_at);
    logic [15:0] s;
    logic [7:0] w;
    exp_t e, got_e;
    int pops, emp_left, first_c, last_c;
    logic done_seen;
    s = 16'hACE1;
    e.words = num; e.errs = 0; e.idx = 0; e.ex = '0; e.ac = '0;
    for (int i = 0; i < num; i++) begin
      w = (i == bad_idx) ? bad_val : s[7:0];
      if (w != s[7:0]) begin
        if (e.errs == 0) begin e.idx = i; e.ex = s[7:0]; e.ac = w; end
        e.errs++;
      end
      mem[wr_ptr] = w;
      wr_ptr++;
      s = prbs_step(s);
    end
    e.pass = (e.errs == 0);
`ifndef FIFO_CHK_ERR_CAPTURE_EN
    e.idx = 0; e.ex = '0; e.ac = '0;
`endif
    sb.push_back(e);
    num_words_i = 16'(num); mode_i = md; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    pops = 0; emp_left = 0; first_c = 0; last_c = 0; done_seen = 1'b0; last_ncyc = 0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      force_empty = emp_left > 0;
      cyc();
      if (force_empty) begin
        check({tag, "_empty_hold"}, popped, 1'b0);
        emp_left--;
      end
      if (popped) begin
        if (pops == 0) first_c = c;
        last_c = c;
        pops++;
        if (pops == emp_at) emp_left = 10;
      end
      done_seen = done_o;
      last_ncyc = c + 1;
    end
    force_empty = 1'b0;
    check({tag, "_done"}, done_seen, 1'b1);
    got_e = sb.pop_front();
    check({tag, "_pops"}, pops, got_e.words);
    check({tag, "_word_cnt"}, word_cnt_o, got_e.words);
    check({tag, "_err_cnt"}, err_cnt_o, got_e.errs);
    check({tag, "_pass"}, pass_o, got_e.pass);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_err_idx"}, err_idx_o, got_e.idx);
    check({tag, "_err_exp"}, err_exp_o, got_e.ex);
    check({tag, "_err_act"}, err_act_o, got_e.ac);
    if (md == 2'd1 && emp_at < 0 && num > 0) check({tag, "_back_to_back"}, last_c - first_c, num - 1);
  endtask

  initial begin
    int pops;
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    check("rst_rd_en", rd_en_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_pass", pass_o, 1'b0);
    check("rst_word_cnt", word_cnt_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_err_idx", err_idx_o, 0);
    cyc();
    run("t1_basic", 4, 2'd1, -1, 8'h00, -1);
    run("t2_corrupt", 4, 2'd1, 1, 8'h00, -1);
    run("t3_empty", 12, 2'd1, -1, 8'h00, 3);
    run("t4_mode3", 32, 2'd3, -1, 8'h00, -1);
    run("t4b_mode2", 10, 2'd2, 7, 8'h5A, -1);
    for (int i = 0; i < 20; i++) mem[wr_ptr + i] = 8'h00;
    wr_ptr += 20;
    num_words_i = 16'd20; mode_i = 2'd1; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    pops = 0;
    for (int c = 0; c < 200 && pops < 5; c++) begin
      cyc();
      if (popped) pops++;
    end
    check("t5_pops_before_abort", pops, 5);
    abort_i = 1'b1; start_i = 1'b1;
    cyc();
    check("t5_abort_rd_en", popped, 1'b0);
    abort_i = 1'b0; start_i = 1'b0;
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (popped) pops++;
    end
    check("t5_no_pops_after", pops, 0);
    check("t5_busy", busy_o, 1'b0);
    check("t5_done", done_o, 1'b0);
    check("t5_word_cnt_le5", word_cnt_o <= 16'd5, 1'b1);
    run("t6_zero", 0, 2'd1, -1, 8'h00, -1);
    check("t6_latency", last_ncyc, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
